// File: rtl/xeng_ctrl_pkg.sv
// Shared definitions for the xeng_ctrl front-end: control-space offsets,
// CTRL/status bit positions, FSM state encoding and an index-width helper.
package xeng_ctrl_pkg;

    localparam logic [1:0] OFF_CTRL = 2'd0;
    localparam logic [1:0] OFF_CLR  = 2'd1;
    localparam logic [1:0] OFF_CYC  = 2'd2;

    localparam int CTRL_RUN   = 0;
    localparam int CTRL_ABORT = 1;

    localparam int ST_DONE = 0;
    localparam int ST_BUSY = 1;
    localparam int ST_PEND = 2;
    localparam int ST_OVF  = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } xeng_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/xeng_ctrl_xconf_queue.sv
// Two-slot configuration buffer: active slot drives the FUs, one pending slot.
// Ports: push/pop/flush/idle/clr_ovf controls, cfg_in, active, pending, overflow.
module xeng_ctrl_xconf_queue
    import xeng_ctrl_pkg::*;
#(
    parameter int CONF_BITS = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic                 pop,
    input  logic                 flush,
    input  logic                 idle,
    input  logic                 clr_ovf,
    input  logic [CONF_BITS-1:0] cfg_in,
    output logic [CONF_BITS-1:0] active,
    output logic                 pending,
    output logic                 overflow
);

    logic [CONF_BITS-1:0] slot;

    // push decisions use the pre-edge pending flag, so a push that
    // coincides with a pop is still judged against the old occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active   <= '0;
            slot     <= '0;
            pending  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (clr_ovf)
                overflow <= 1'b0;
            if (flush) begin
                pending <= 1'b0;
            end else begin
                if (pop) begin
                    active  <= slot;
                    pending <= 1'b0;
                end
                if (push) begin
                    if (pending) begin
                        overflow <= 1'b1;
                    end else if (idle) begin
                        active <= cfg_in;
                    end else begin
                        slot    <= cfg_in;
                        pending <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/xeng_ctrl.sv
// Data-engine control front-end: host decode, run queue, run FSM, status.
// Ports: clk, rst, host valid/we/addr/rdata(in)/wdata(out), mem_valid,
// mem_rdata, fu_done, config_bus, config_out, run.
// Option: XENG_CYCLE_CNT_EN adds a WAIT-cycle counter readable at CYC.
module xeng_ctrl
    import xeng_ctrl_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int DATAPATH_W = 32,
    parameter int N_MEM      = 4,
    parameter int MEM_ADDR_W = 10,
    parameter int N_DONE     = 4,
    parameter int CONF_BITS  = 256,
    parameter int DONE_GUARD = 2,
    localparam int N_MEM_W   = idx_w(N_MEM),
    localparam int AW        = N_MEM_W + MEM_ADDR_W + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        valid,
    input  logic                        we,
    input  logic [AW-1:0]               addr,
    input  logic [DATA_W-1:0]           rdata,
    output logic [DATA_W-1:0]           wdata,
    output logic [N_MEM-1:0]            mem_valid,
    input  logic [N_MEM*DATAPATH_W-1:0] mem_rdata,
    input  logic [N_DONE-1:0]           fu_done,
    input  logic [CONF_BITS-1:0]        config_bus,
    output logic [CONF_BITS-1:0]        config_out,
    output logic                        run
);

    localparam int GW = $clog2(DONE_GUARD + 2);

    xeng_state_t state, state_nxt;

    logic [GW-1:0]      guard;
    logic               busy, pending, overflow, idle;
    logic               ctrl_sp, host_wr, ctrl_wr;
    logic               abort, run_req, clr_ovf, complete, pop;
    logic [N_MEM_W-1:0] mem_idx, rd_idx;
    logic [1:0]         off, rd_off;
    logic               rd_pend, rd_ctrl;
    logic [DATAPATH_W-1:0] mem_word;
    logic [DATA_W-1:0]  mem_ext, ctrl_val, cyc_val;
    logic [3:0]         status;
    logic               unused_bits;

    assign ctrl_sp  = addr[AW-1];
    assign mem_idx  = addr[AW-2 -: N_MEM_W];
    assign off      = addr[1:0];
    assign host_wr  = valid & we & ctrl_sp;
    assign ctrl_wr  = host_wr & (off == OFF_CTRL);
    assign abort    = ctrl_wr & rdata[CTRL_ABORT];
    assign run_req  = ctrl_wr & rdata[CTRL_RUN] & ~rdata[CTRL_ABORT];
    assign clr_ovf  = host_wr & (off == OFF_CLR);
    assign idle     = (state == S_IDLE);
    assign complete = (state == S_WAIT) & (guard == '0) & (&fu_done);
    // a pending config left over in IDLE (queued in the completion cycle)
    // is launched from IDLE, costing at most one idle cycle
    assign pop      = ~abort & pending & (idle | complete);

    assign unused_bits = ^{rdata[DATA_W-1:2], addr[MEM_ADDR_W-1:2]};

    always_comb begin
        mem_valid = '0;
        for (int i = 0; i < N_MEM; i++)
            mem_valid[i] = valid & ~ctrl_sp & (mem_idx == N_MEM_W'(i));
    end

    xeng_ctrl_xconf_queue #(
        .CONF_BITS (CONF_BITS)
    ) u_queue (
        .clk      (clk),
        .rst      (rst),
        .push     (run_req),
        .pop      (pop),
        .flush    (abort),
        .idle     (idle),
        .clr_ovf  (clr_ovf),
        .cfg_in   (config_bus),
        .active   (config_out),
        .pending  (pending),
        .overflow (overflow)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (run_req | pending) state_nxt = S_START;
            S_START: state_nxt = S_WAIT;
            S_WAIT:  if (complete) state_nxt = pending ? S_START : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (abort)
            state_nxt = S_IDLE;
    end

    always_comb begin
        run  = (state == S_START);
        busy = (state == S_START) | (state == S_WAIT);
    end

    // masks stale done flags left high from the previous run
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            guard <= '0;
        else if (state == S_START)
            guard <= GW'(DONE_GUARD);
        else if (state == S_WAIT && guard != '0)
            guard <= guard - GW'(1);
    end

`ifdef XENG_CYCLE_CNT_EN
    logic [31:0] cyc_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cyc_cnt <= '0;
        else if (state == S_START)
            cyc_cnt <= '0;
        else if (state == S_WAIT)
            cyc_cnt <= cyc_cnt + 32'd1;
    end

    assign cyc_val = DATA_W'(cyc_cnt);
`else
    assign cyc_val = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend <= 1'b0;
            rd_ctrl <= 1'b0;
            rd_idx  <= '0;
            rd_off  <= '0;
        end else begin
            rd_pend <= valid & ~we;
            if (valid & ~we) begin
                rd_ctrl <= ctrl_sp;
                rd_idx  <= mem_idx;
                rd_off  <= off;
            end
        end
    end

    always_comb begin
        status          = '0;
        status[ST_DONE] = ~busy & ~pending;
        status[ST_BUSY] = busy;
        status[ST_PEND] = pending;
        status[ST_OVF]  = overflow;
    end

    // memory data arrives the cycle after the access, so the lane is
    // picked from the registered index; unmatched index reads 0
    always_comb begin
        mem_word = '0;
        for (int i = 0; i < N_MEM; i++)
            if (rd_idx == N_MEM_W'(i))
                mem_word = mem_rdata[(N_MEM-1-i)*DATAPATH_W +: DATAPATH_W];
        mem_ext = {DATA_W{mem_word[DATAPATH_W-1]}};
        mem_ext[DATAPATH_W-1:0] = mem_word;
    end

    always_comb begin
        ctrl_val = '0;
        case (rd_off)
            OFF_CTRL: ctrl_val = DATA_W'(status);
            OFF_CYC:  ctrl_val = cyc_val;
            default:  ctrl_val = '0;
        endcase
    end

    always_comb begin
        wdata = '0;
        if (rd_pend)
            wdata = rd_ctrl ? ctrl_val : mem_ext;
    end

endmodule
